pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
- Parametrised program-counter unit; successor to the plain PC register.
- Adds:
  - stall and fetch handshake to instruction memory;
  - branch/jump redirect;
  - trap vectoring;
  - misaligned-target detection;
  - halt/resume state machine;
  - accepted-fetch counter.
- Sits at the head of the fetch stage and drives the instruction-memory address.

Parameters:
- XLEN, 32, PC and address width.
- RESET_VECTOR, 32'h0000_0000, PC value on reset; must be 4-byte aligned.
- TRAP_VECTOR, 32'h0000_0100, PC loaded on trap or misaligned redirect; must be 4-byte aligned.
- INC, 4, sequential increment in bytes.
- CNT_W, 32, width of fetch_count.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- stall  in  1  hold PC (pipeline hazard)
- redirect_valid  in  1  take redirect_target this cycle
- redirect_target  in  XLEN  branch/jump destination
- trap_valid  in  1  exception/interrupt request
- halt_req  in  1  request to enter HALT
- resume  in  1  leave HALT
- fetch_ready  in  1  instruction memory accepts current pc
- pc  out  XLEN  current fetch address (registered)
- pc_plus_inc  out  XLEN  pc + INC (combinational)
- fetch_valid  out  1  pc is a valid fetch request
- misaligned  out  1  one-cycle pulse: rejected misaligned redirect
- misaligned_addr  out  XLEN  last rejected target
- state  out  2  FSM state (0 BOOT, 1 RUN, 2 HALT)
- fetch_count  out  CNT_W  number of accepted fetches

Behaviour:
- Reset (async, active-high, dominates all inputs, including mid-operation):
  - pc=RESET_VECTOR, state=BOOT, misaligned=0, misaligned_addr=0, fetch_count=0.
  - fetch_valid=0 while reset is high.
- FSM:
  - BOOT lasts exactly one clock after reset deasserts, then goes to RUN; all inputs are ignored in BOOT.
  - RUN: halt_req -> HALT next cycle.
  - HALT: resume -> RUN next cycle.
  - HALT: trap_valid -> RUN with pc=TRAP_VECTOR.
  - Encoding 2'b11 is unreachable; if reached, go to BOOT.
- fetch_valid = (state==RUN), combinational from registered state.
- Handshake: a fetch is accepted when fetch_valid && fetch_ready && !stall.
- PC next-value priority in RUN, highest first:
  1. trap_valid -> TRAP_VECTOR.
  2. redirect_valid with target[1:0]!=0 -> TRAP_VECTOR; misaligned=1 next cycle for one cycle; misaligned_addr<=target.
  3. redirect_valid aligned -> redirect_target.
  4. Accepted fetch -> pc+INC.
  5. Otherwise hold.
- Trap and redirect apply regardless of stall and fetch_ready, i.e. the in-flight fetch is squashed.
- Single-cycle latency: an input sampled at edge N sets pc visible after edge N.
- Simultaneous events:
  - trap_valid with halt_req: trap wins, state stays RUN.
  - redirect with halt_req: redirect taken and state goes to HALT; pc holds the redirect target while halted.
  - resume and halt_req both high in HALT: resume wins.
- HALT: pc holds, no increment, redirect ignored, fetch_count holds.
- Arithmetic:
  - pc+INC wraps modulo 2^XLEN (32'hFFFF_FFFC -> 32'h0000_0000).
  - fetch_count increments by 1 per accepted fetch only and wraps at 2^CNT_W; it is not incremented by a redirect or trap cycle.
- misaligned is low on every cycle except the one following a rejected redirect.
- Elaboration check: RESET_VECTOR[1:0] and TRAP_VECTOR[1:0] must be 0; a non-zero value is a fatal elaboration error.

Decomposition:
- Package pc_pkg:
  - state encodings ST_BOOT/ST_RUN/ST_HALT;
  - next-PC select codes SEL_TRAP/SEL_MISAL/SEL_REDIR/SEL_INC/SEL_HOLD;
  - alignment-mask constant.
- One combinational sub-module, pc_next_sel:
  - inputs: state, trap, redirect, target, accept, pc;
  - outputs: select code and next_pc.
  - pc_unit holds the registers, FSM, counter and misaligned pulse.

Test Plan:
- Reset with RESET_VECTOR=0x100, release, fetch_ready=1: cycle 1 state=BOOT, fetch_valid=0; then pc=0x100,0x104,0x108 and fetch_count=1,2,3.
- stall=1 for 3 cycles, or fetch_ready=0, at pc=0x20 -> pc stays 0x20 and fetch_count unchanged; release -> 0x24.
- redirect 0x400 together with stall=1 -> next pc=0x400. Same cycle trap_valid=1 -> pc=TRAP_VECTOR 0x100 instead.
- Redirect to 0x402 -> pc=0x100, misaligned high for exactly one cycle, misaligned_addr=0x402.
- pc=0xFFFF_FFFC, accepted fetch -> pc=0x0. CNT_W=4: after 16 fetches fetch_count=0.
- halt_req at pc=0x50 -> state=HALT, fetch_valid=0, pc=0x50 held 5 cycles, redirect ignored. resume -> RUN, pc advances to 0x54. Async reset asserted mid-HALT -> pc=RESET_VECTOR immediately, state=BOOT.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared encodings for the program-counter unit: FSM states, next-PC select
// codes and the instruction alignment mask.
package pc_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        SEL_HOLD  = 3'd0,
        SEL_INC   = 3'd1,
        SEL_REDIR = 3'd2,
        SEL_MISAL = 3'd3,
        SEL_TRAP  = 3'd4
    } sel_e;

    localparam logic [1:0] ALIGN_MASK = 2'b11;

    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return (low_bits & ALIGN_MASK) != 2'b00;
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC selector: priority trap > misaligned redirect >
// redirect > accepted fetch > hold.
module pc_next_sel
    import pc_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] TRAP_VECTOR = XLEN'(32'h0000_0100),
    parameter int              INC         = 4
) (
    input  logic [1:0]      state,
    input  logic            trap,
    input  logic            redirect,
    input  logic [XLEN-1:0] target,
    input  logic            accept,
    input  logic [XLEN-1:0] pc,
    output sel_e            sel,
    output logic [XLEN-1:0] next_pc
);

    always_comb begin
        sel = SEL_HOLD;
        if (state == ST_RUN) begin
            if (trap) begin
                sel = SEL_TRAP;
            end else if (redirect && is_misaligned(target[1:0])) begin
                sel = SEL_MISAL;
            end else if (redirect) begin
                sel = SEL_REDIR;
            end else if (accept) begin
                sel = SEL_INC;
            end
        end else if (state == ST_HALT && trap) begin
            // A trap wakes a halted core straight into the handler.
            sel = SEL_TRAP;
        end
    end

    always_comb begin
        next_pc = pc;
        case (sel)
            SEL_TRAP, SEL_MISAL: next_pc = TRAP_VECTOR;
            SEL_REDIR:           next_pc = target;
            SEL_INC:             next_pc = pc + XLEN'(INC);
            default:             next_pc = pc;
        endcase
    end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: PC register, BOOT/RUN/HALT control, fetch handshake,
// redirect/trap handling, misaligned-target reporting and accepted-fetch count.
module pc_unit
    import pc_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
    parameter int              INC          = 4,
    parameter int              CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_target,
    input  logic             trap_valid,
    input  logic             halt_req,
    input  logic             resume,
    input  logic             fetch_ready,
    output logic [XLEN-1:0]  pc,
    output logic [XLEN-1:0]  pc_plus_inc,
    output logic             fetch_valid,
    output logic             misaligned,
    output logic [XLEN-1:0]  misaligned_addr,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] fetch_count
);

    if ((RESET_VECTOR[1:0] & ALIGN_MASK) != 2'b00) begin : g_bad_reset_vector
        $fatal(1, "pc_unit: RESET_VECTOR must be 4-byte aligned");
    end
    if ((TRAP_VECTOR[1:0] & ALIGN_MASK) != 2'b00) begin : g_bad_trap_vector
        $fatal(1, "pc_unit: TRAP_VECTOR must be 4-byte aligned");
    end

    state_e            state_reg;
    logic [XLEN-1:0]   pc_reg;
    logic              misaligned_reg;
    logic [XLEN-1:0]   misaligned_addr_reg;
    logic [CNT_W-1:0]  fetch_count_reg;
    logic              accept;
    sel_e              sel;
    logic [XLEN-1:0]   pc_next;

    assign fetch_valid = (state_reg == ST_RUN);
    assign accept      = fetch_valid && fetch_ready && !stall;

    pc_next_sel #(
        .XLEN        (XLEN),
        .TRAP_VECTOR (TRAP_VECTOR),
        .INC         (INC)
    ) u_next_sel (
        .state    (state_reg),
        .trap     (trap_valid),
        .redirect (redirect_valid),
        .target   (redirect_target),
        .accept   (accept),
        .pc       (pc_reg),
        .sel      (sel),
        .next_pc  (pc_next)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg           <= ST_BOOT;
            pc_reg              <= RESET_VECTOR;
            misaligned_reg      <= 1'b0;
            misaligned_addr_reg <= '0;
            fetch_count_reg     <= '0;
        end else begin
            pc_reg         <= pc_next;
            misaligned_reg <= (sel == SEL_MISAL);
            if (sel == SEL_MISAL) begin
                misaligned_addr_reg <= redirect_target;
            end
            // Only a plain sequential advance counts; squashed fetches do not.
            if (sel == SEL_INC) begin
                fetch_count_reg <= fetch_count_reg + CNT_W'(1);
            end
            case (state_reg)
                ST_BOOT: state_reg <= ST_RUN;
                ST_RUN: begin
                    if (!trap_valid && halt_req) begin
                        state_reg <= ST_HALT;
                    end
                end
                ST_HALT: begin
                    if (resume || trap_valid) begin
                        state_reg <= ST_RUN;
                    end
                end
                default: state_reg <= ST_BOOT;
            endcase
        end
    end

    assign pc              = pc_reg;
    assign pc_plus_inc     = pc_reg + XLEN'(INC);
    assign misaligned      = misaligned_reg;
    assign misaligned_addr = misaligned_addr_reg;
    assign state           = state_reg;
    assign fetch_count     = fetch_count_reg;

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: the driver queues hand-computed expectations,
// a monitor pops and compares them after each clock edge or reset assertion.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic        trap_valid = 1'b0;
    logic        halt_req = 1'b0;
    logic        resume = 1'b0;
    logic        fetch_ready = 1'b1;
    logic [31:0] pc;
    logic [31:0] pc_plus_inc;
    logic        fetch_valid;
    logic        misaligned;
    logic [31:0] misaligned_addr;
    logic [1:0]  state;
    logic [3:0]  fetch_count;

    int checks = 0;
    int failures = 0;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic [1:0]  st;
        logic        mis;
        logic [31:0] maddr;
        logic [3:0]  cnt;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    pc_unit #(
        .XLEN         (32),
        .RESET_VECTOR (32'h0000_0100),
        .TRAP_VECTOR  (32'h0000_0100),
        .INC          (4),
        .CNT_W        (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .trap_valid      (trap_valid),
        .halt_req        (halt_req),
        .resume          (resume),
        .fetch_ready     (fetch_ready),
        .pc              (pc),
        .pc_plus_inc     (pc_plus_inc),
        .fetch_valid     (fetch_valid),
        .misaligned      (misaligned),
        .misaligned_addr (misaligned_addr),
        .state           (state),
        .fetch_count     (fetch_count)
    );

    task automatic chk(input string tname, input string field,
                       input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s.%s actual=%h expected=%h", tname, field, act, expv);
        end
    endtask

    // Monitor: one transaction per clock edge (or reset assertion) that has a queued expectation.
    initial begin
        exp_t e;
        logic [31:0] e_inc;
        forever begin
            @(posedge clk or posedge reset);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                e_inc = e.pc + 32'd4;
                chk(e.name, "pc", pc, e.pc);
                chk(e.name, "pc_plus_inc", pc_plus_inc, e_inc);
                chk(e.name, "state", {30'd0, state}, {30'd0, e.st});
                chk(e.name, "fetch_valid", {31'd0, fetch_valid}, {31'd0, (e.st == 2'd1)});
                chk(e.name, "misaligned", {31'd0, misaligned}, {31'd0, e.mis});
                chk(e.name, "misaligned_addr", misaligned_addr, e.maddr);
                chk(e.name, "fetch_count", {28'd0, fetch_count}, {28'd0, e.cnt});
                $display("txn %-16s pc=%h state=%0d fv=%0b mis=%0b maddr=%h cnt=%0d",
                         e.name, pc, state, fetch_valid, misaligned, misaligned_addr, fetch_count);
            end
        end
    end

    task automatic push(input string name, input logic [31:0] epc, input logic [1:0] est,
                        input logic emis, input logic [31:0] emaddr, input logic [3:0] ecnt);
        exp_t e;
        e.name = name; e.pc = epc; e.st = est; e.mis = emis; e.maddr = emaddr; e.cnt = ecnt;
        exp_q.push_back(e);
    endtask

    task automatic cyc(input string name, input logic rst, input logic rv, input logic [31:0] tgt,
                       input logic tr, input logic hr, input logic rs, input logic stl, input logic fr,
                       input logic [31:0] epc, input logic [1:0] est, input logic emis,
                       input logic [31:0] emaddr, input logic [3:0] ecnt);
        @(negedge clk);
        reset = rst; redirect_valid = rv; redirect_target = tgt; trap_valid = tr;
        halt_req = hr; resume = rs; stall = stl; fetch_ready = fr;
        push(name, epc, est, emis, emaddr, ecnt);
    endtask

    initial begin
        // Reset, BOOT, sequential fetch
        cyc("rst_hold",    1, 0, 32'h0,        0, 0, 0, 0, 1, 32'h100, 0, 0, 32'h0, 0);
        cyc("boot_exit",   0, 0, 32'h0,        0, 0, 0, 0, 1, 32'h100, 1, 0, 32'h0, 0);
        cyc("seq1",        0, 0, 32'h0,        0, 0, 0, 0, 1, 32'h104, 1, 0, 32'h0, 1);
        cyc("seq2",        0, 0, 32'h0,        0, 0, 0, 0, 1, 32'h108, 1, 0, 32'h0, 2);
        cyc("seq3",        0, 0, 32'h0,        0, 0, 0, 0, 1, 32'h10C, 1, 0, 32'h0, 3);
        // Stall / not-ready hold
        cyc("redir_20",    0, 1, 32'h20,       0, 0, 0, 0, 1, 32'h20,  1, 0, 32'h0, 3);
        for (int i = 0; i < 3; i++)
            cyc("stall",   0, 0, 32'h0,        0, 0, 0, 1, 1, 32'h20,  1, 0, 32'h0, 3);
        cyc("not_ready",   0, 0, 32'h0,        0, 0, 0, 0, 0, 32'h20,  1, 0, 32'h0, 3);
        cyc("release",     0, 0, 32'h0,        0, 0, 0, 0, 1, 32'h24,  1, 0, 32'h0, 4);
        // Redirect and trap override stall
        cyc("redir_stall", 0, 1, 32'h400,      0, 0, 0, 1, 1, 32'h400, 1, 0, 32'h0, 4);
        cyc("trap_redir",  0, 1, 32'h400,      1, 0, 0, 1, 1, 32'h100, 1, 0, 32'h0, 4);
        cyc("after_trap",  0, 0, 32'h0,        0, 0, 0, 0, 1, 32'h104, 1, 0, 32'h0, 5);
        // Misaligned redirect
        cyc("misal",       0, 1, 32'h402,      0, 0, 0, 0, 1, 32'h100, 1, 1, 32'h402, 5);
        cyc("misal_clr",   0, 0, 32'h0,        0, 0, 0, 0, 1, 32'h104, 1, 0, 32'h402, 6);
        // PC wrap and counter wrap (16th accepted fetch brings count to 0)
        cyc("to_top",      0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, 1, 32'hFFFF_FFFC, 1, 0, 32'h402, 6);
        cyc("pc_wrap",     0, 0, 32'h0,        0, 0, 0, 0, 1, 32'h0,   1, 0, 32'h402, 7);
        for (int i = 1; i <= 9; i++)
            cyc("cnt_run", 0, 0, 32'h0,        0, 0, 0, 0, 1, 32'(4 * i), 1, 0, 32'h402, 4'(7 + i));
        // HALT behaviour
        cyc("redir_halt",  0, 1, 32'h50,       0, 1, 0, 0, 1, 32'h50,  2, 0, 32'h402, 0);
        for (int i = 0; i < 5; i++)
            cyc("halt_hold", 0, 1, 32'h800,    0, 1'(i % 2), 0, 0, 1, 32'h50, 2, 0, 32'h402, 0);
        cyc("resume_win",  0, 0, 32'h0,        0, 1, 1, 0, 1, 32'h50,  1, 0, 32'h402, 0);
        cyc("resume_run",  0, 0, 32'h0,        0, 0, 0, 0, 1, 32'h54,  1, 0, 32'h402, 1);
        cyc("halt_inc",    0, 0, 32'h0,        0, 1, 0, 0, 1, 32'h58,  2, 0, 32'h402, 2);
        cyc("halt_trap",   0, 0, 32'h0,        1, 0, 0, 0, 1, 32'h100, 1, 0, 32'h402, 2);
        cyc("halt_again",  0, 0, 32'h0,        0, 1, 0, 0, 1, 32'h104, 2, 0, 32'h402, 3);
        // Asynchronous reset in the middle of HALT
        @(negedge clk);
        halt_req = 1'b0;
        #2;
        push("async_rst", 32'h100, 0, 0, 32'h0, 0);
        reset = 1'b1;
        cyc("rst_mid_hold", 1, 0, 32'h0,       0, 0, 0, 0, 1, 32'h100, 0, 0, 32'h0, 0);
        cyc("boot_exit2",  0, 0, 32'h0,        0, 0, 0, 0, 1, 32'h100, 1, 0, 32'h0, 0);
        cyc("trap_vs_halt", 0, 0, 32'h0,       1, 1, 0, 0, 1, 32'h100, 1, 0, 32'h0, 0);
        cyc("final",       0, 0, 32'h0,        0, 0, 0, 0, 1, 32'h104, 1, 0, 32'h0, 1);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
